mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/arb_pick.sv | 16 +
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 10;

  // Requester ids; the id of the last grant is latched as a single bit.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between instruction and data requesters.
// On a tie the prio input names the winner, so a constant gives fixed
// priority and a toggling pointer gives round-robin.
module arb_pick import mem_arb_pkg::*; (
  input  logic iReq,
  input  logic dReq,
  input  logic prio,
  output logic winId
);
  // A lone requester wins outright; prio only matters when both ask.
  always_comb begin
    winId = REQ_D;
    if (iReq && dReq) winId = prio;
    else if (iReq)    winId = REQ_I;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one
// synchronous single-port RAM. One access per two cycles:
// IDLE/RESP arbitrate -> ACCESS drives the RAM -> RESP returns the word.
// Build option: define MEM_ARB_RR_EN for round-robin on ties; otherwise
// data always wins a tie.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);
  state_t              state, stateNxt;
  logic                winId, latWe, latErr;
  logic [ADDR_W-1:0]   latAddr;
  logic [31:0]         latWdata;
  logic                anyReq, pickId, pickErr, prio, fire;
  logic [31:0]         pickAddr;

  // Byte-offset bits of fetches and address bits beyond the RAM are dropped.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{i_addr[1:0], i_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

  assign anyReq   = i_req | d_req;
  assign fire     = anyReq && (state == IDLE || state == RESP);
  assign pickAddr = (pickId == REQ_D) ? d_addr : i_addr;
  assign pickErr  = (pickId == REQ_D) && (d_addr[1:0] != 2'b00);

`ifdef MEM_ARB_RR_EN
  logic rrPtr;
  // The tie winner yields the next tie; lone grants leave the pointer alone.
  always_ff @(posedge clk or posedge rst)
    if (rst)                          rrPtr <= REQ_D;
    else if (fire && i_req && d_req)  rrPtr <= ~pickId;
  assign prio = rrPtr;
`else
  assign prio = REQ_D;
`endif

  arb_pick uPick (
    .iReq  (i_req),
    .dReq  (d_req),
    .prio  (prio),
    .winId (pickId)
  );

  // State register; async reset also kills an in-flight ACCESS so no write commits.
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= stateNxt;

  // Capture the winner's request so the requester may drop req after grant.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      winId    <= REQ_D;
      latWe    <= 1'b0;
      latErr   <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
    end else if (fire) begin
      winId    <= pickId;
      latWe    <= (pickId == REQ_D) && d_we;
      latErr   <= pickErr;
      latAddr  <= pickAddr[ADDR_W+1:2];
      latWdata <= (pickId == REQ_D) ? d_wdata : '0;
    end

  // Next state and all outputs; everything is zero unless the state drives it.
  always_comb begin
    stateNxt = state;
    mem_en   = 1'b0;
    mem_we   = 4'h0;
    mem_addr = '0;
    mem_din  = '0;
    i_ready  = 1'b0;
    i_rdata  = '0;
    d_ready  = 1'b0;
    d_err    = 1'b0;
    d_rdata  = '0;
    case (state)
      IDLE: if (anyReq) stateNxt = pickErr ? RESP : ACCESS;
      ACCESS: begin
        mem_en   = 1'b1;
        mem_we   = latWe ? 4'hF : 4'h0;
        mem_addr = latAddr;
        mem_din  = latWdata;
        stateNxt = RESP;
      end
      RESP: begin
        if (winId == REQ_D) begin
          d_ready = 1'b1;
          d_err   = latErr;
          d_rdata = (latWe || latErr) ? '0 : mem_dout;
        end else begin
          i_ready = 1'b1;
          i_rdata = mem_dout;
        end
        if (anyReq) stateNxt = pickErr ? RESP : ACCESS;
        else        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a RAM model and a response scoreboard.
module tb_mem_arbiter;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we;
  logic [31:0]   i_addr, d_addr, d_wdata;
  logic          i_ready, d_ready, d_err;
  logic [31:0]   i_rdata, d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din, mem_dout;

  logic [31:0] ram    [2**AW];
  logic [31:0] refMem [2**AW];

  typedef struct {logic isD; logic err; logic [31:0] rdata;} exp_t;
  exp_t expQ[$];

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous read-first RAM with byte write enables.
  always @(posedge clk)
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
      mem_dout <= ram[mem_addr];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic isD, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    if (isD) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin i_req = 1'b1; i_addr = addr; end
  endtask

  task automatic expectResp(input logic isD, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    logic [AW-1:0] idx;
    idx     = addr[AW+1:2];
    e.isD   = isD;
    e.err   = isD && (addr[1:0] != 2'b00);
    e.rdata = '0;
    if (!e.err) begin
      if (isD && we) refMem[idx] = wdata;
      else           e.rdata = refMem[idx];
    end
    expQ.push_back(e);
  endtask

  task automatic issue(input logic isD, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    drive(isD, we, addr, wdata);
    expectResp(isD, we, addr, wdata);
  endtask

  // Step until a ready appears (bounded), then pop and compare one response.
  task automatic waitResp(output int lat, output int enCnt, output int weCnt, output logic [31:0] lastAddr);
    exp_t e;
    lat = 0; enCnt = 0; weCnt = 0; lastAddr = '0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_en) begin enCnt++; lastAddr = 32'(mem_addr); end
      if (mem_we == 4'hF) weCnt++;
      if (!(i_ready || d_ready)) begin
        chk("quiet rdata", i_rdata | d_rdata, 32'h0);
        chk("quiet err", 32'(d_err), 32'h0);
      end
    end while (!(i_ready || d_ready) && lat < 8);
    if (!(i_ready || d_ready)) begin
      chk("ready timeout", 32'h0, 32'h1);
      return;
    end
    if (expQ.size() == 0) begin
      chk("unexpected ready", 32'(expQ.size()), 32'h1);
      return;
    end
    e = expQ.pop_front();
    chk("ready pair", 32'({i_ready, d_ready}), e.isD ? 32'h1 : 32'h2);
    chk("rdata", e.isD ? d_rdata : i_rdata, e.rdata);
    chk("d_err", 32'(d_err), 32'(e.err));
  endtask

  initial begin
    int lat, enCnt, weCnt;
    logic [31:0] lastAddr;

    for (int i = 0; i < 2**AW; i++) begin
      ram[i]    = 32'hA500_0000 ^ (32'(i) * 32'h0001_0003);
      refMem[i] = ram[i];
    end
    ram[2] = 32'h2010_0005; refMem[2] = 32'h2010_0005;

    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;

    // Reset: requests are ignored and every output sits at zero.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h8;
    @(negedge clk);
    @(negedge clk);
    chk("rst ctl", 32'({mem_en, mem_we, i_ready, d_ready, d_err}), 32'h0);
    chk("rst mem_addr", 32'(mem_addr), 32'h0);
    chk("rst mem_din", mem_din, 32'h0);
    chk("rst rdata", i_rdata | d_rdata, 32'h0);
    i_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Single fetch of word 2.
    issue(1'b0, 1'b0, 32'h0000_0008, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    chk("fetch lat", 32'(lat), 32'd2);
    chk("fetch mem_addr", lastAddr, 32'd2);
    chk("fetch en cnt", 32'(enCnt), 32'd1);
    // Fetch with stray low bits and high bits still hits word 2.
    issue(1'b0, 1'b0, 32'hFFFF_F00B, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    chk("wrap mem_addr", lastAddr, 32'd2);
    i_req = 1'b0;
    @(negedge clk);

    // Store then load of 0x14.
    issue(1'b1, 1'b1, 32'h14, 32'hDEAD_BEEF);
    waitResp(lat, enCnt, weCnt, lastAddr);
    chk("store we cnt", 32'(weCnt), 32'd1);
    chk("store mem_addr", lastAddr, 32'd5);
    chk("store lat", 32'(lat), 32'd2);
    issue(1'b1, 1'b0, 32'h14, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    chk("load we cnt", 32'(weCnt), 32'd0);
    d_req = 1'b0;
    @(negedge clk);

    // Misaligned load and store never touch the RAM.
    issue(1'b1, 1'b0, 32'h6, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    chk("misal en cnt", 32'(enCnt), 32'd0);
    chk("misal lat", 32'(lat), 32'd1);
    issue(1'b1, 1'b1, 32'h16, 32'h1111_2222);
    waitResp(lat, enCnt, weCnt, lastAddr);
    chk("misal wr en cnt", 32'(enCnt), 32'd0);
    issue(1'b1, 1'b0, 32'h14, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    d_req = 1'b0;
    @(negedge clk);

    // Back-to-back loads with d_req held: ready every second cycle.
    issue(1'b1, 1'b0, 32'h8, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    chk("b2b lat0", 32'(lat), 32'd2);
    issue(1'b1, 1'b0, 32'hC, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    chk("b2b lat1", 32'(lat), 32'd2);
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    chk("b2b lat2", 32'(lat), 32'd2);
    d_req = 1'b0;
    @(negedge clk);

    // Tie between fetch and load; grant order depends on the build.
    drive(1'b0, 1'b0, 32'h8, 32'h0);
    drive(1'b1, 1'b0, 32'hC, 32'h0);
    expectResp(1'b1, 1'b0, 32'hC, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    chk("tie lat0", 32'(lat), 32'd2);
`ifdef MEM_ARB_RR_EN
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    expectResp(1'b0, 1'b0, 32'h8, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    drive(1'b0, 1'b0, 32'h4, 32'h0);
    expectResp(1'b1, 1'b0, 32'h10, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    d_req = 1'b0;
    expectResp(1'b0, 1'b0, 32'h4, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    chk("tie lat3", 32'(lat), 32'd2);
`else
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    expectResp(1'b1, 1'b0, 32'h10, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    d_req = 1'b0;
    expectResp(1'b0, 1'b0, 32'h8, 32'h0);
    waitResp(lat, enCnt, weCnt, lastAddr);
    chk("tie lat2", 32'(lat), 32'd2);
`endif
    i_req = 1'b0;
    @(negedge clk);

    // Reset during the ACCESS of a store to 0x20.
    drive(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    @(negedge clk);
    chk("mid we before rst", 32'(mem_we), 32'hF);
    rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("rst kills we", 32'({mem_en, mem_we}), 32'h0);
    @(negedge clk);
    chk("ram8 intact", ram[8], refMem[8]);
    chk("no ready in rst", 32'({i_ready, d_ready}), 32'h0);
    // Request pending at release is arbitrated on the first edge.
    issue(1'b1, 1'b0, 32'h20, 32'h0);
    rst = 1'b0;
    waitResp(lat, enCnt, weCnt, lastAddr);
    chk("post rst lat", 32'(lat), 32'd2);
    d_req = 1'b0;
    @(negedge clk);
    chk("queue drained", 32'(expQ.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
